// File: rtl/fact_engine.sv
// fact_engine: multi-cycle N! coprocessor built around a radix-2 shift-add
// multiplier. Each iteration multiplies the accumulator by k (NBITS cycles),
// then decrements k until k <= 1. Overflow is sticky per operation, and the
// result either saturates to all-ones or wraps modulo 2^WIDTH.
module fact_engine #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NBITS = 5,
  parameter bit          SAT   = 1'b1
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             start,
  input  logic [NBITS-1:0] n_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  // Partial product is wide enough to hold acc * k without losing bits.
  localparam int unsigned PW = WIDTH + NBITS;
  localparam int unsigned CW = $clog2(NBITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_UPD,
    S_DONE
  } state_t;

  state_t           state;
  logic [NBITS-1:0] k;
  logic [WIDTH-1:0] acc;
  logic [PW-1:0]    partial;
  logic [NBITS-1:0] mplr;
  logic [CW-1:0]    bitcnt;
  logic             ovf_sticky;

  logic [PW-1:0]    addend_c;
  logic             ovf_now_c;
  logic             last_bit_c;

  // Shifted multiplicand, upper-bit overflow detect and final-bit flag.
  assign addend_c   = PW'(acc) << bitcnt;
  assign ovf_now_c  = |partial[PW-1:WIDTH];
  assign last_bit_c = (bitcnt == CW'(NBITS - 1));

  // Controller and datapath; the overflow output tracks the internal sticky
  // flag only at completion, so result/overflow stay stable between pulses.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      k          <= '0;
      acc        <= '0;
      partial    <= '0;
      mplr       <= '0;
      bitcnt     <= '0;
      ovf_sticky <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= '0;
      overflow   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            k          <= n_in;
            acc        <= WIDTH'(1);
            ovf_sticky <= 1'b0;
            busy       <= 1'b1;
            state      <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (k <= NBITS'(1)) begin
            state <= S_DONE;
          end else begin
            partial <= '0;
            mplr    <= k;
            bitcnt  <= '0;
            state   <= S_MUL;
          end
        end
        S_MUL: begin
          if (mplr[0]) begin
            partial <= partial + addend_c;
          end
          mplr   <= mplr >> 1;
          bitcnt <= bitcnt + CW'(1);
          if (last_bit_c) begin
            state <= S_UPD;
          end
        end
        S_UPD: begin
          if (ovf_now_c) begin
            ovf_sticky <= 1'b1;
          end
          acc   <= (SAT && (ovf_now_c || ovf_sticky)) ? '1 : partial[WIDTH-1:0];
          k     <= k - NBITS'(1);
          state <= S_CHECK;
        end
        S_DONE: begin
          result   <= acc;
          overflow <= ovf_sticky;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fact_engine.sv
// tb_fact_engine: four fact_engine instances (32/16-bit, saturate/wrap) share
// stimulus; expected results are queued at start and checked when done fires.
module tb_fact_engine;

  localparam int NB = 5;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        start;
  logic [4:0]  n_in;

  logic        busy_a, done_a, ovf_a;
  logic [31:0] res_a;
  logic        busy_b, done_b, ovf_b;
  logic [31:0] res_b;
  logic        busy_c, done_c, ovf_c;
  logic [15:0] res_c;
  logic        busy_d, done_d, ovf_d;
  logic [15:0] res_d;

  logic [31:0] res [4];
  logic        ovf [4];
  logic        dn  [4];
  logic        bsy [4];

  typedef struct packed {
    int              n;
    int              lat;
    logic [3:0][31:0] r;
    logic [3:0]      o;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk1 = ~clk1;

  fact_engine #(.WIDTH(32), .NBITS(NB), .SAT(1'b1)) u_w32_sat (
    .clk1(clk1), .rst_n(rst_n), .start(start), .n_in(n_in),
    .busy(busy_a), .done(done_a), .result(res_a), .overflow(ovf_a));
  fact_engine #(.WIDTH(32), .NBITS(NB), .SAT(1'b0)) u_w32_wrap (
    .clk1(clk1), .rst_n(rst_n), .start(start), .n_in(n_in),
    .busy(busy_b), .done(done_b), .result(res_b), .overflow(ovf_b));
  fact_engine #(.WIDTH(16), .NBITS(NB), .SAT(1'b0)) u_w16_wrap (
    .clk1(clk1), .rst_n(rst_n), .start(start), .n_in(n_in),
    .busy(busy_c), .done(done_c), .result(res_c), .overflow(ovf_c));
  fact_engine #(.WIDTH(16), .NBITS(NB), .SAT(1'b1)) u_w16_sat (
    .clk1(clk1), .rst_n(rst_n), .start(start), .n_in(n_in),
    .busy(busy_d), .done(done_d), .result(res_d), .overflow(ovf_d));

  always_comb begin
    res[0] = res_a;          ovf[0] = ovf_a; dn[0] = done_a; bsy[0] = busy_a;
    res[1] = res_b;          ovf[1] = ovf_b; dn[1] = done_b; bsy[1] = busy_b;
    res[2] = {16'h0, res_c}; ovf[2] = ovf_c; dn[2] = done_c; bsy[2] = busy_c;
    res[3] = {16'h0, res_d}; ovf[3] = ovf_d; dn[3] = done_d; bsy[3] = busy_d;
  end

  function automatic int width_of(input int d);
    return (d < 2) ? 32 : 16;
  endfunction

  function automatic bit sat_of(input int d);
    return (d == 0) || (d == 3);
  endfunction

  // Reference: repeated multiply by N, N-1, ..., 2 with sticky overflow.
  function automatic void model(input int n, input int w, input bit sat,
                                output logic [31:0] r, output logic o);
    longint unsigned acc;
    longint unsigned p;
    longint unsigned mask;
    mask = (64'd1 << w) - 64'd1;
    acc  = 64'd1;
    o    = 1'b0;
    for (int i = n; i >= 2; i--) begin
      p = acc * 64'(i);
      if ((p >> w) != 64'd0) o = 1'b1;
      acc = (sat && o) ? mask : (p & mask);
    end
    r = 32'(acc);
  endfunction

  // Drive one start pulse (called at a negedge) and queue its expectation.
  task automatic issue(input int n);
    exp_t e;
    logic [31:0] r;
    logic o;
    e.n   = n;
    e.lat = (n <= 1) ? 2 : (n - 1) * (NB + 2) + 2;
    for (int d = 0; d < 4; d++) begin
      model(n, width_of(d), sat_of(d), r, o);
      e.r[d] = r;
      e.o[d] = o;
    end
    sb.push_back(e);
    start = 1'b1;
    n_in  = 5'(n);
    @(posedge clk1);
    #1 start = 1'b0;
  endtask

  // Count edges since the accept edge until done is seen (bounded).
  task automatic wait_done(input int start_cyc, input bit junk,
                           output int cyc, output bit seen, output int busy_low);
    cyc = start_cyc;
    seen = 1'b0;
    busy_low = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(posedge clk1);
      cyc++;
      @(negedge clk1);
      if (dn[0]) begin
        seen  = 1'b1;
        start = 1'b0;
      end else begin
        if (!bsy[0]) busy_low++;
        if (junk) begin
          start = 1'($urandom);
          n_in  = 5'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    n_in  = '0;
    repeat (2) @(negedge clk1);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (res[d] !== 32'h0 || ovf[d] !== 1'b0 || bsy[d] !== 1'b0 || dn[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d got res=%h ovf=%b busy=%b done=%b want all zero",
                 d, res[d], ovf[d], bsy[d], dn[d]);
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk1);
  endtask

  // Small N, 32-bit fit/overflow boundary and 16-bit boundary on all instances.
  task automatic test_function();
    int ns[7] = '{0, 1, 7, 8, 9, 12, 13};
    int cyc, bl;
    bit seen;
    exp_t e;
    foreach (ns[i]) begin
      issue(ns[i]);
      wait_done(0, 1'b0, cyc, seen, bl);
      e = sb.pop_front();
      checks++;
      if (!seen || cyc != e.lat) begin
        errors++;
        $display("FAIL latency n=%0d got %0d cycles (seen=%0b) want %0d", e.n, cyc, seen, e.lat);
      end
      for (int d = 0; d < 4; d++) begin
        checks++;
        if (res[d] !== e.r[d] || ovf[d] !== e.o[d] || dn[d] !== 1'b1) begin
          errors++;
          $display("FAIL func dut%0d n=%0d got res=%h ovf=%b done=%b want res=%h ovf=%b done=1",
                   d, e.n, res[d], ovf[d], dn[d], e.r[d], e.o[d]);
        end
      end
      @(negedge clk1);
      checks++;
      if (dn[0] !== 1'b0 || bsy[0] !== 1'b0) begin
        errors++;
        $display("FAIL pulse n=%0d got done=%b busy=%b want done=0 busy=0", e.n, dn[0], bsy[0]);
      end
    end
  endtask

  // Starts and n_in changes while busy must not disturb an N=5 run.
  task automatic test_busy();
    int cyc, bl, extra;
    bit seen;
    exp_t e;
    issue(5);
    wait_done(0, 1'b1, cyc, seen, bl);
    e = sb.pop_front();
    checks++;
    if (!seen || cyc != e.lat || bl != 0) begin
      errors++;
      $display("FAIL busy_run got %0d cycles seen=%0b busy_low=%0d want %0d cycles busy_low=0",
               cyc, seen, bl, e.lat);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (res[d] !== e.r[d] || ovf[d] !== e.o[d]) begin
        errors++;
        $display("FAIL busy dut%0d got res=%h ovf=%b want res=%h ovf=%b",
                 d, res[d], ovf[d], e.r[d], e.o[d]);
      end
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk1);
      if (dn[0] || bsy[0]) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_single got %0d extra done/busy cycles want 0", extra);
    end
  endtask

  // N=13 then N=4 accepted in the done cycle; overflow must clear.
  task automatic test_back_to_back();
    int cyc, bl;
    bit seen;
    exp_t e, prev;
    issue(13);
    wait_done(0, 1'b0, cyc, seen, bl);
    prev = sb.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (!seen || res[d] !== prev.r[d] || ovf[d] !== prev.o[d]) begin
        errors++;
        $display("FAIL b2b_first dut%0d got res=%h ovf=%b seen=%0b want res=%h ovf=%b",
                 d, res[d], ovf[d], seen, prev.r[d], prev.o[d]);
      end
    end
    issue(4);
    repeat (5) @(negedge clk1);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (res[d] !== prev.r[d] || ovf[d] !== prev.o[d] || bsy[d] !== 1'b1) begin
        errors++;
        $display("FAIL hold dut%0d got res=%h ovf=%b busy=%b want res=%h ovf=%b busy=1",
                 d, res[d], ovf[d], bsy[d], prev.r[d], prev.o[d]);
      end
    end
    wait_done(4, 1'b0, cyc, seen, bl);
    e = sb.pop_front();
    checks++;
    if (!seen || cyc != e.lat) begin
      errors++;
      $display("FAIL b2b_latency got %0d cycles seen=%0b want %0d", cyc, seen, e.lat);
    end
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (res[d] !== e.r[d] || ovf[d] !== e.o[d]) begin
        errors++;
        $display("FAIL b2b dut%0d got res=%h ovf=%b want res=%h ovf=%b",
                 d, res[d], ovf[d], e.r[d], e.o[d]);
      end
    end
    @(negedge clk1);
  endtask

  // Reset during MUL of N=7 aborts silently; N=3 afterwards completes.
  task automatic test_reset_midrun();
    int cyc, bl, stray;
    bit seen;
    exp_t e;
    issue(7);
    repeat (10) @(negedge clk1);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_front());
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (res[d] !== 32'h0 || ovf[d] !== 1'b0 || bsy[d] !== 1'b0) begin
        errors++;
        $display("FAIL abort dut%0d got res=%h ovf=%b busy=%b want 0/0/0",
                 d, res[d], ovf[d], bsy[d]);
      end
    end
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
    stray = 0;
    repeat (60) begin
      @(negedge clk1);
      if (dn[0] || bsy[0]) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL abort_quiet got %0d done/busy cycles after reset want 0", stray);
    end
    issue(3);
    wait_done(0, 1'b0, cyc, seen, bl);
    e = sb.pop_front();
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (!seen || cyc != e.lat || res[d] !== e.r[d] || ovf[d] !== e.o[d]) begin
        errors++;
        $display("FAIL after_reset dut%0d got res=%h ovf=%b cyc=%0d want res=%h ovf=%b cyc=%0d",
                 d, res[d], ovf[d], cyc, e.r[d], e.o[d], e.lat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_function();
    test_busy();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_engine.md
Name: fact_engine

Overview:
- Parametrised multi-cycle factorial coprocessor for the pipe_MIPS32 datapath.
- Offloads the software N! loop (MUL/SUBI/BNEQZ with dummy hazard fillers) to dedicated hardware.
- Accepts N on a start strobe and computes N! with a radix-2 shift-add multiplier. Returns a WIDTH-bit result with sticky overflow, selectable saturate or wrap.
- Sits beside the register file, driven by a single-phase clock.

Parameters:
- WIDTH, 32, accumulator/result width in bits (>= NBITS+1).
- NBITS, 5, width of operand N; also the number of shift-add cycles per multiply.
- SAT, 1, 1 = saturate result to all-ones on overflow; 0 = keep low WIDTH bits (modulo 2^WIDTH).

Ports:
- clk1, input, 1, single system clock; all state updates on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request pulse; sampled only in IDLE.
- n_in, input, NBITS, operand N; captured on the accepted start edge.
- busy, output, 1, high from the cycle after start is accepted until the DONE state is left.
- done, output, 1, one-cycle pulse; result/overflow valid.
- result, output, WIDTH, N! (saturated or wrapped); held until next done.
- overflow, output, 1, sticky per operation; set if any intermediate product exceeds 2^WIDTH-1.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, overflow=0; acc, k, partial, mplr and bitcnt are cleared. Reset mid-operation aborts with no done pulse.
- State machine, all outputs registered.
  - IDLE: start=1 captures k<=n_in, acc<=1, overflow<=0, busy<=1, then goes to CHECK. start=0 stays in IDLE.
  - CHECK:
    - k<=1 goes to DONE.
    - Otherwise partial<=0, mplr<=k, bitcnt<=0, then goes to MUL.
  - MUL (exactly NBITS cycles), each cycle:
    - If mplr[0], partial <= partial + (acc << bitcnt).
    - mplr >>= 1; bitcnt++.
    - After the NBITS-th cycle, goes to UPD.
    - partial is WIDTH+NBITS bits wide, so it never overflows internally.
  - UPD:
    - ovf_now = (partial[WIDTH+NBITS-1:WIDTH] != 0).
    - If ovf_now, overflow<=1.
    - acc <= (SAT && (ovf_now || overflow)) ? all-ones : partial[WIDTH-1:0].
    - k <= k-1; goes to CHECK.
  - DONE: result<=acc, done=1 for this single cycle. busy<=0 on exit; goes to IDLE.
- Latency from the start-accept edge to the done cycle:
  - N in {0,1}: 2 cycles; result=1, overflow=0.
  - N >= 2: (N-1)*(NBITS+2)+2 cycles. Example: N=7, NBITS=5 gives 44.
- Throughput: a new start can be accepted in the first IDLE cycle after DONE; no back-to-back overlap.
- start while busy (CHECK/MUL/UPD/DONE) is ignored, not queued; n_in changes while busy have no effect.
- overflow is sticky within one operation and cleared on the next accepted start.
- SAT=1: once overflowed, acc stays all-ones for the remaining iterations.
- SAT=0: the wrapped value propagates through the remaining iterations (true N! mod 2^WIDTH).
- result and overflow are stable between done pulses, including while a new operation runs. Both update only in DONE.

Test Plan:
- Reset while running: rst_n low during MUL at N=7 -> busy=0, result=0, overflow=0 immediately; no done pulse. The next start with N=3 completes normally with result=6.
- Small N (WIDTH=32, NBITS=5): N=0 -> result=1 and N=1 -> result=1, done 2 cycles after start. N=7 -> result=5040, overflow=0, done exactly 44 cycles after the start edge.
- Boundary fit/overflow (WIDTH=32, NBITS=5):
  - N=12 -> result=479001600, overflow=0.
  - N=13, SAT=1 -> result=32'hFFFFFFFF, overflow=1.
  - N=13, SAT=0 -> result=1932053504, overflow=1.
- Narrow width (WIDTH=16, NBITS=5):
  - N=8 -> result=40320, overflow=0.
  - N=9, SAT=0 -> result=16'h8980, overflow=1.
  - N=9, SAT=1 -> result=16'hFFFF, overflow=1.
- Busy rules: start pulses and n_in changes during an N=5 run are ignored -> single done with result=120. A new start in the first IDLE cycle after done with N=4 -> result=24, overflow cleared.
